// File: rtl/my_resp_router.sv
// my_resp_router: return path from ALU1/ALU2 to the four requester ports.
// Each port has a registered one-cycle output stage backed by a small FIFO.
// The FIFO absorbs same-cycle collisions and drains one entry per cycle in arrival order.
module my_resp_router #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              alu1_out_vld,
    input  logic [1:0]        alu1_out_req_id,
    input  logic [1:0]        alu1_out_resp,
    input  logic [DATA_W-1:0] alu1_out_data,
    input  logic              alu2_out_vld,
    input  logic [1:0]        alu2_out_req_id,
    input  logic [1:0]        alu2_out_resp,
    input  logic [DATA_W-1:0] alu2_out_data,
    output logic              alu2_out_rdy,
    output logic [1:0]        out_resp1,
    output logic [1:0]        out_resp2,
    output logic [1:0]        out_resp3,
    output logic [1:0]        out_resp4,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [DATA_W-1:0] out_data4,
    output logic [3:0]        resp_pending,
    output logic              resp_err
);

    localparam int unsigned NPORT  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned CAND_N = DEPTH + 2;

    typedef struct packed {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           fifo_q [NPORT][DEPTH];
    entry_t           fifo_d [NPORT][DEPTH];
    entry_t           out_q  [NPORT];
    entry_t           out_d  [NPORT];
    logic [CNT_W-1:0] cnt_q  [NPORT];
    logic [CNT_W-1:0] cnt_d  [NPORT];
    logic [3:0]       pending_q, pending_d;
    logic             err_q, err_d;

    logic             alu2_full_c;
    logic             acc1_c;
    logic             acc2_c;
    logic             ill1_c;
    logic             ill2_c;

    // ALU2 is only refused when it collides with ALU1 on a port whose FIFO is full
    assign alu2_full_c  = (cnt_q[alu2_out_req_id] == CNT_W'(DEPTH));
    assign alu2_out_rdy = !(alu2_out_vld && alu1_out_vld &&
                            (alu1_out_req_id == alu2_out_req_id) && alu2_full_c);

    // Accepted results with a legal code are routed; resp 00 is dropped and flagged
    assign acc1_c = alu1_out_vld && (alu1_out_resp != 2'b00);
    assign acc2_c = alu2_out_vld && alu2_out_rdy && (alu2_out_resp != 2'b00);
    assign ill1_c = alu1_out_vld && (alu1_out_resp == 2'b00);
    assign ill2_c = alu2_out_vld && alu2_out_rdy && (alu2_out_resp == 2'b00);

    // Per-port next state: candidates are FIFO head, then ALU1, then ALU2
    always_comb begin
        entry_t cand [CAND_N];
        int     n;
        fifo_d    = fifo_q;
        cnt_d     = cnt_q;
        pending_d = '0;
        err_d     = err_q | ill1_c | ill2_c;
        for (int p = 0; p < NPORT; p++) begin
            out_d[p] = '0;
            for (int i = 0; i < CAND_N; i++) begin
                cand[i] = '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                cand[i] = fifo_q[p][i];
            end
            n = int'(cnt_q[p]);
            if (acc1_c && (int'(alu1_out_req_id) == p)) begin
                for (int j = 0; j < CAND_N; j++) begin
                    if (j == n) begin
                        cand[j] = {alu1_out_resp, alu1_out_data};
                    end
                end
                n = n + 1;
            end
            if (acc2_c && (int'(alu2_out_req_id) == p)) begin
                for (int j = 0; j < CAND_N; j++) begin
                    if (j == n) begin
                        cand[j] = {alu2_out_resp, alu2_out_data};
                    end
                end
                n = n + 1;
            end
            if (n > 0) begin
                out_d[p] = cand[0];
                for (int i = 0; i < DEPTH; i++) begin
                    fifo_d[p][i] = cand[i+1];
                end
                cnt_d[p] = CNT_W'(n - 1);
            end else begin
                cnt_d[p] = '0;
            end
            pending_d[p] = (n > 1);
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NPORT; p++) begin
                out_q[p] <= '0;
                cnt_q[p] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    fifo_q[p][i] <= '0;
                end
            end
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            fifo_q    <= fifo_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign out_resp1    = out_q[0].resp;
    assign out_resp2    = out_q[1].resp;
    assign out_resp3    = out_q[2].resp;
    assign out_resp4    = out_q[3].resp;
    assign out_data1    = out_q[0].data;
    assign out_data2    = out_q[1].data;
    assign out_data3    = out_q[2].data;
    assign out_data4    = out_q[3].data;
    assign resp_pending = pending_q;
    assign resp_err     = err_q;

endmodule

// File: tb/tb_my_resp_router.sv
// Bench for my_resp_router: directed scenarios plus random traffic against a queue model.
module tb_my_resp_router;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned DATA_W = 32;

    logic              c_clk = 1'b0;
    logic              reset;
    logic              alu1_out_vld;
    logic [1:0]        alu1_out_req_id;
    logic [1:0]        alu1_out_resp;
    logic [DATA_W-1:0] alu1_out_data;
    logic              alu2_out_vld;
    logic [1:0]        alu2_out_req_id;
    logic [1:0]        alu2_out_resp;
    logic [DATA_W-1:0] alu2_out_data;
    logic              alu2_out_rdy;
    logic [1:0]        out_resp1, out_resp2, out_resp3, out_resp4;
    logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;
    logic [3:0]        resp_pending;
    logic              resp_err;

    my_resp_router #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .c_clk(c_clk), .reset(reset),
        .alu1_out_vld(alu1_out_vld), .alu1_out_req_id(alu1_out_req_id),
        .alu1_out_resp(alu1_out_resp), .alu1_out_data(alu1_out_data),
        .alu2_out_vld(alu2_out_vld), .alu2_out_req_id(alu2_out_req_id),
        .alu2_out_resp(alu2_out_resp), .alu2_out_data(alu2_out_data),
        .alu2_out_rdy(alu2_out_rdy),
        .out_resp1(out_resp1), .out_resp2(out_resp2), .out_resp3(out_resp3), .out_resp4(out_resp4),
        .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3), .out_data4(out_data4),
        .resp_pending(resp_pending), .resp_err(resp_err)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [1:0]        r;
        logic [DATA_W-1:0] d;
    } ent_t;

    // Model: every accepted, not-yet-emitted result per port, oldest first
    ent_t mq [4][$];
    bit   exp_err;
    bit   last_rdy;
    int   checks;
    int   failures;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [1:0] get_resp(input int p);
        case (p)
            0: return out_resp1;
            1: return out_resp2;
            2: return out_resp3;
            default: return out_resp4;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] get_data(input int p);
        case (p)
            0: return out_data1;
            1: return out_data2;
            2: return out_data3;
            default: return out_data4;
        endcase
    endfunction

    task automatic set_in(input bit v1, input int id1, input int r1, input logic [DATA_W-1:0] d1,
                          input bit v2, input int id2, input int r2, input logic [DATA_W-1:0] d2);
        alu1_out_vld    = v1;
        alu1_out_req_id = 2'(id1);
        alu1_out_resp   = 2'(r1);
        alu1_out_data   = d1;
        alu2_out_vld    = v2;
        alu2_out_req_id = 2'(id2);
        alu2_out_resp   = 2'(r2);
        alu2_out_data   = d2;
    endtask

    task automatic set_idle();
        set_in(0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic check_all_idle(input string tag);
        for (int p = 0; p < 4; p++) begin
            check_eq({tag, "_resp"}, 64'(get_resp(p)), 64'd0);
            check_eq({tag, "_data"}, 64'(get_data(p)), 64'd0);
        end
        check_eq({tag, "_pend"}, 64'(resp_pending), 64'd0);
        check_eq({tag, "_err"}, 64'(resp_err), 64'd0);
    endtask

    // One clock with the current inputs; starts and ends 1 time unit after a rising edge
    task automatic step();
        bit   rdy_e;
        ent_t e;
        #2;
        rdy_e = !(alu2_out_vld && alu1_out_vld && (alu1_out_req_id == alu2_out_req_id) &&
                  (mq[alu2_out_req_id].size() == DEPTH));
        check_eq("rdy", 64'(alu2_out_rdy), 64'(rdy_e));
        last_rdy = rdy_e;
        @(posedge c_clk);
        if (alu1_out_vld) begin
            if (alu1_out_resp == 2'b00) exp_err = 1'b1;
            else mq[alu1_out_req_id].push_back('{r: alu1_out_resp, d: alu1_out_data});
        end
        if (alu2_out_vld && rdy_e) begin
            if (alu2_out_resp == 2'b00) exp_err = 1'b1;
            else mq[alu2_out_req_id].push_back('{r: alu2_out_resp, d: alu2_out_data});
        end
        #1;
        for (int p = 0; p < 4; p++) begin
            if (mq[p].size() > 0) e = mq[p].pop_front();
            else e = '{r: 2'b00, d: '0};
            check_eq($sformatf("resp%0d", p + 1), 64'(get_resp(p)), 64'(e.r));
            check_eq($sformatf("data%0d", p + 1), 64'(get_data(p)), 64'(e.d));
            check_eq($sformatf("pend%0d", p + 1), 64'(resp_pending[p]), 64'(mq[p].size() != 0));
        end
        check_eq("err", 64'(resp_err), 64'(exp_err));
    endtask

    task automatic clear_model();
        for (int p = 0; p < 4; p++) mq[p].delete();
        exp_err = 1'b0;
    endtask

    initial begin
        bit   h2;
        int   k;
        bit   v1;
        int   id1, id2, r1, r2;
        logic [DATA_W-1:0] d1, d2;
        checks   = 0;
        failures = 0;
        exp_err  = 1'b0;
        reset    = 1'b0;
        set_idle();
        repeat (3) @(posedge c_clk);
        #1;
        check_all_idle("in_reset");
        @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk);
        #1;

        // Idle after reset
        repeat (10) step();

        // Single ALU1 result to port 2
        set_in(1, 1, 1, 32'h0000_0005, 0, 0, 0, '0);
        step();
        set_idle();
        repeat (2) step();

        // Same-cycle collision on port 3
        set_in(1, 2, 1, 32'h0000_000A, 1, 2, 1, 32'h0000_000B);
        step();
        set_idle();
        repeat (3) step();

        // Back-to-back collisions on port 1 force ALU2 backpressure
        k  = 1;
        h2 = 1'b0;
        d2 = '0;
        while (k <= 3 || h2) begin
            if (!h2) d2 = 32'h0000_00B0 + DATA_W'(k);
            if (k <= 3) set_in(1, 0, 1, 32'h0000_00A0 + DATA_W'(k), 1, 0, 1, d2);
            else        set_in(0, 0, 0, '0, 1, 0, 1, d2);
            step();
            h2 = !last_rdy;
            if (k <= 3) k++;
        end
        set_idle();
        repeat (4) step();

        // Different ports in the same cycle
        set_in(1, 0, 1, 32'h1, 1, 3, 1, 32'h2);
        step();
        set_idle();
        repeat (2) step();

        // Random traffic; a refused ALU2 result is held until accepted
        h2 = 1'b0;
        id2 = 0; r2 = 1; d2 = '0;
        for (int c = 0; c < 400; c++) begin
            v1  = ($urandom_range(0, 9) < 6);
            id1 = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 3));
            r1  = int'($urandom_range(1, 3));
            d1  = $urandom;
            if (!h2) begin
                id2 = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 3));
                r2  = int'($urandom_range(1, 3));
                d2  = $urandom;
                h2  = ($urandom_range(0, 9) < 6);
            end
            set_in(v1, id1, r1, d1, h2, id2, r2, d2);
            step();
            h2 = h2 && !last_rdy;
        end
        set_idle();
        repeat (4) step();

        // Illegal response code is dropped and flags a sticky error
        set_in(1, 1, 0, 32'hDEAD, 0, 0, 0, '0);
        step();
        set_idle();
        repeat (3) step();

        // Build up queued entries on port 1, then reset mid-operation
        set_in(1, 0, 2, 32'hC1, 1, 0, 3, 32'hC2);
        step();
        set_in(1, 0, 1, 32'hC3, 1, 0, 1, 32'hC4);
        step();
        set_idle();
        #2;
        reset = 1'b0;
        #1;
        check_all_idle("async_rst");
        clear_model();
        repeat (2) @(posedge c_clk);
        @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk);
        #1;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/my_resp_router.md
Name: my_resp_router

Overview:
- Return-path block of calc1: collects completed results from ALU1 (add/sub) and ALU2 (shift) and routes each result back to the requesting port, 1-4.
- Routing uses the 2-bit req_id that the dispatch/priority logic tagged onto the command.
- Sits between the ALU output stage and the four port response buses.
- Serialises to one response per port per cycle, with a small per-port queue to absorb same-cycle collisions.

Parameters:
DEPTH, 2, per-port holding queue entries (1..4)
DATA_W, 32, result data width

Ports:
c_clk  in  1  block clock, rising edge
reset  in  1  asynchronous, active-low reset
alu1_out_vld  in  1  ALU1 result valid, single-cycle qualifier
alu1_out_req_id  in  2  target port of ALU1 result: 00=p1, 01=p2, 10=p3, 11=p4
alu1_out_resp  in  2  ALU1 response code: 01 ok, 10 overflow/underflow/invalid, 11 reserved, 00 illegal with vld
alu1_out_data  in  DATA_W  ALU1 result data
alu2_out_vld  in  1  ALU2 result valid
alu2_out_req_id  in  2  target port of ALU2 result
alu2_out_resp  in  2  ALU2 response code
alu2_out_data  in  DATA_W  ALU2 result data
alu2_out_rdy  out  1  ALU2 result accepted this cycle (combinational)
out_resp1..out_resp4  out  2  per-port response code; 00 = no response this cycle
out_data1..out_data4  out  DATA_W  per-port response data; 0 when out_respN = 00
resp_pending  out  4  bit N-1 set when queue of port N is non-empty
resp_err  out  1  sticky protocol error flag

Behaviour:
- Reset (async assert, sync release): all out_respN = 00, out_dataN = 0, all queues empty, resp_pending = 0, resp_err = 0.
- Each port has an output register plus a FIFO of DEPTH entries {resp, data}; count_p ranges 0..DEPTH.
- Acceptance:
  - ALU1 result is always accepted when alu1_out_vld = 1.
  - alu2_out_rdy = !(alu2_out_vld && alu1_out_vld && alu1_out_req_id == alu2_out_req_id && count_p == DEPTH), where p = alu2_out_req_id.
  - Otherwise alu2_out_rdy = 1.
  - A refused ALU2 result is held stable by ALU2 until accepted.
- Per-port update at each rising edge:
  - Candidate order: FIFO head (oldest), then accepted ALU1 result, then accepted ALU2 result.
  - First candidate loads the output register; the remaining candidates push into the FIFO in that order.
  - No candidates: output register loads resp 00, data 0.
- Output timing:
  - Each response appears for exactly one cycle; there is no hold and no port-side backpressure.
  - Latency: result accepted at edge T with the port queue empty drives out_respN at T+1, visible until T+2.
  - Queued results drain one per cycle in arrival order. Per-port order is ALU1 before ALU2 for same-cycle arrivals; otherwise arrival order.
- Invariants:
  - Occupancy never exceeds DEPTH; the acceptance rule guarantees count_p + arrivals - 1 <= DEPTH.
  - Different target ports are fully independent. Both ALUs to different ports in one cycle produce two outputs at T+1.
- Illegal response code: vld = 1 with resp = 00 is dropped (not enqueued, not output) and sets resp_err. resp_err clears only on reset.
- resp_pending reflects FIFO count after the edge (registered).
- Reset asserted mid-operation: queued and in-flight results are discarded immediately; outputs go to 00/0 asynchronously.
- resp 11 is passed through unmodified.

Test Plan:
- Reset then idle 10 cycles -> all out_respN = 00, out_dataN = 0, resp_pending = 0000, resp_err = 0, alu2_out_rdy = 1.
- alu1 vld, id 01, resp 01, data 0x0000_0005 at edge T -> out_resp2 = 01, out_data2 = 5 during cycle T+1 only; other ports 00.
- Same cycle: alu1 id 10 (data 0xA) and alu2 id 10 (data 0xB) -> out_resp3 carries 0xA at T+1, 0xB at T+2; resp_pending[2] = 1 during T+1 only.
- DEPTH = 2: 3 consecutive cycles of both ALUs targeting id 00 -> alu2_out_rdy drops to 0 in the cycle count = 2; port 1 emits 0x..A1,B1,A2,B2,A3,B3 in order, with no gap or loss.
- Simultaneous alu1 id 00 (0x1) and alu2 id 11 (0x2) -> out_resp1 = 01 / 0x1 and out_resp4 = 01 / 0x2 both at T+1.
- alu1 vld with resp 00 -> no output on any port, resp_err = 1 and stays 1. Then assert reset with 2 entries queued -> queues cleared, resp_err = 0, no residual output after release.
